// File: rtl/uart_rx_intr.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_intr
//  Description : 8N1 UART receiver that feeds a CPU level interrupt.
//                Each received byte is presented on rx_data and irr is raised
//                until the CPU acknowledges it with a rising edge on ack.
//                Framing errors and overruns are reported as 1-cycle pulses.
//                Optional macro UART_RX_MAJORITY_EN selects a 2-of-3 majority
//                vote around every sample point (decisions one cycle later).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_intr #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       ack,
    output logic       irr,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    // The counter starts at 0 in the cycle after the falling edge is seen,
    // so the start sample (H-1 cycles after the edge) is at cnt == H-2.
    // With the majority vote the decision is taken one cycle later.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 1);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 2);
`endif
    // Every subsequent decision is one full bit period after the previous one.
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
            $error("uart_rx_intr: CLKS_PER_BIT must be >= 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    logic             rx_meta;
    logic             rxs;
    logic             bit_val;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             ack_q;
    logic             ack_rise;
    logic             start_tick;
    logic             bit_tick;
    logic             commit;

    // Two-flop synchroniser on the asynchronous serial pin; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d1;
    logic rxs_d2;

    // Two cycles of synchronised history so the vote can see sample-1 and sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxs_d1 <= 1'b1;
            rxs_d2 <= 1'b1;
        end else begin
            rxs_d1 <= rxs;
            rxs_d2 <= rxs_d1;
        end
    end

    // 2-of-3 vote of the line at sample-1, sample and sample+1.
    assign bit_val = (rxs_d2 & rxs_d1) | (rxs_d2 & rxs) | (rxs_d1 & rxs);
`else
    assign bit_val = rxs;
`endif

    assign ack_rise   = ack & ~ack_q;
    assign start_tick = (cnt == START_LAST);
    assign bit_tick   = (cnt == BIT_LAST);
    assign commit     = (state == STOP) && bit_tick && bit_val;

    // Receive FSM plus the interrupt/acknowledge handshake and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            ack_q     <= 1'b0;
            irr       <= 1'b0;
            rx_data   <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            ack_q     <= ack;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                START: begin
                    if (start_tick) begin
                        cnt <= '0;
                        if (bit_val) begin
                            // Line bounced back high: treat as a glitch.
                            state <= IDLE;
                        end else begin
                            bit_idx <= 3'd0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            // Byte is discarded; wait for the line to recover.
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    cnt <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase

            // A commit wins over a coincident ack: the ack retires the old
            // byte and the new one becomes pending, so irr stays high.
            if (commit) begin
                rx_data <= shreg;
                irr     <= 1'b1;
                overrun <= irr & ~ack_rise;
            end else if (ack_rise) begin
                irr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_intr.sv
`default_nettype none
module tb_uart_rx_intr;

    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 155;
`else
    localparam int LAT = 154;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic       ack   = 1'b0;
    logic       irr;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun;

    int n_cmp  = 0;
    int n_bad  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;

    uart_rx_intr #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .ack      (ack),
        .irr      (irr),
        .rx_data  (rx_data),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every commit (irr rising, overrun, or a new byte
    // while irr stays high) pops the next expected byte.
    logic       irr_p  = 1'b0;
    logic       fe_p   = 1'b0;
    logic       ov_p   = 1'b0;
    logic [7:0] data_p = 8'h00;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if ((irr && !irr_p) || overrun || (irr && rx_data !== data_p)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_commit: got byte %h, none expected", rx_data);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (rx_data !== sb_exp) begin
                        n_bad++;
                        $display("FAIL sb_commit: rx_data %h, expected %h", rx_data, sb_exp);
                    end
                end
            end
            if (!irr && rx_data !== data_p) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_data_stable: changed %h -> %h with irr=0", data_p, rx_data);
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if ((frame_err && fe_p) || (overrun && ov_p) || (frame_err && overrun)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pulse_shape: frame_err %b/%b overrun %b/%b (prev/now)",
                         fe_p, frame_err, ov_p, overrun);
            end
        end
        irr_p  <= irr;
        data_p <= rx_data;
        fe_p   <= frame_err;
        ov_p   <= overrun;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 160-cycle frame; optional 1-cycle inverted spike at each data
    // sample point. Leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit spike);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            logic v;
            v = bits[c / CPB];
            if (spike && (c % CPB) == 7 && c >= CPB && c < 9 * CPB) v = ~v;
            rxd = v;
            cycles(1);
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; rxd = 1'b1; ack = 1'b0;
        cycles(3);
        n_cmp++; if (irr !== 1'b0)       begin n_bad++; $display("FAIL reset_irr: got %b want 0", irr); end
        n_cmp++; if (rx_data !== 8'h00)  begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0)   begin n_bad++; $display("FAIL reset_ov: got %b want 0", overrun); end
        reset = 1'b0;
        cycles(2);
        // Reset in the middle of a frame must abort it silently.
        rxd = 1'b0;
        cycles(60);
        reset = 1'b1;
        cycles(2);
        rxd = 1'b1;
        reset = 1'b0;
        cycles(200);
        n_cmp++; if (irr !== 1'b0) begin n_bad++; $display("FAIL reset_abort_irr: got %b want 0", irr); end
        n_cmp++; if (fe_cnt !== 0) begin n_bad++; $display("FAIL reset_abort_fe: count %0d want 0", fe_cnt); end
    endtask

    task automatic test_single();
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                cycles(LAT - 1);
                n_cmp++; if (irr !== 1'b0) begin n_bad++; $display("FAIL latency_early: irr %b want 0", irr); end
                cycles(1);
                n_cmp++; if (irr !== 1'b1) begin n_bad++; $display("FAIL latency: irr %b want 1", irr); end
            end
        join
        n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", rx_data); end
        ack = 1'b1;
        cycles(1);
        n_cmp++; if (irr !== 1'b0) begin n_bad++; $display("FAIL ack_clear: irr %b want 0", irr); end
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            n_cmp++; if (irr !== 1'b0) begin n_bad++; $display("FAIL ack_hold_%0d: irr %b want 0", i, irr); end
        end
        // A held ack must not retire a byte that arrives later.
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 1'b0);
        n_cmp++; if (irr !== 1'b1) begin n_bad++; $display("FAIL held_ack_once: irr %b want 1", irr); end
        n_cmp++; if (rx_data !== 8'h96) begin n_bad++; $display("FAIL held_ack_data: got %h want 96", rx_data); end
        ack = 1'b0;
        cycles(2);
        ack_pulse();
        n_cmp++; if (irr !== 1'b0) begin n_bad++; $display("FAIL held_ack_clear: irr %b want 0", irr); end
    endtask

    task automatic test_back_to_back();
        int ov0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b1, 1'b0);
        n_cmp++; if (irr !== 1'b1)      begin n_bad++; $display("FAIL b2b_first_irr: got %b want 1", irr); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL b2b_first_data: got %h want 3c", rx_data); end
        send_frame(8'hC3, 1'b1, 1'b0);
        n_cmp++; if (irr !== 1'b1)      begin n_bad++; $display("FAIL b2b_second_irr: got %b want 1", irr); end
        n_cmp++; if (rx_data !== 8'hC3) begin n_bad++; $display("FAIL b2b_second_data: got %h want c3", rx_data); end
        n_cmp++; if (ov_cnt !== ov0 + 1) begin n_bad++; $display("FAIL b2b_overrun: pulses %0d want %0d", ov_cnt - ov0, 1); end
        ack_pulse();
        n_cmp++; if (irr !== 1'b0) begin n_bad++; $display("FAIL b2b_clear: irr %b want 0", irr); end
    endtask

    task automatic test_ack_collision();
        int ov0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        n_cmp++; if (irr !== 1'b1) begin n_bad++; $display("FAIL coll_pending: irr %b want 1", irr); end
        ov0 = ov_cnt;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                cycles(LAT - 1);
                ack = 1'b1;
                cycles(1);
                ack = 1'b0;
            end
        join
        n_cmp++; if (irr !== 1'b1)      begin n_bad++; $display("FAIL coll_irr: got %b want 1", irr); end
        n_cmp++; if (rx_data !== 8'h55) begin n_bad++; $display("FAIL coll_data: got %h want 55", rx_data); end
        n_cmp++; if (ov_cnt !== ov0)    begin n_bad++; $display("FAIL coll_overrun: pulses %0d want 0", ov_cnt - ov0); end
        ack_pulse();
        n_cmp++; if (irr !== 1'b0) begin n_bad++; $display("FAIL coll_clear: irr %b want 0", irr); end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'hFF, 1'b0, 1'b0);
        cycles(100);
        n_cmp++; if (fe_cnt !== fe0 + 1)  begin n_bad++; $display("FAIL ferr_count: pulses %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (rx_data !== 8'h55)   begin n_bad++; $display("FAIL ferr_data: got %h want 55", rx_data); end
        n_cmp++; if (irr !== 1'b0)        begin n_bad++; $display("FAIL ferr_irr: got %b want 0", irr); end
        rxd = 1'b1;
        cycles(200);
        n_cmp++; if (fe_cnt !== fe0 + 1)  begin n_bad++; $display("FAIL break_single: pulses %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (irr !== 1'b0)        begin n_bad++; $display("FAIL break_irr: got %b want 0", irr); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        rxd = 1'b0;
        cycles(4);
        rxd = 1'b1;
        cycles(40);
        n_cmp++; if (irr !== 1'b0)   begin n_bad++; $display("FAIL glitch_irr: got %b want 0", irr); end
        n_cmp++; if (fe_cnt !== fe0) begin n_bad++; $display("FAIL glitch_fe: pulses %0d want 0", fe_cnt - fe0); end
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 1'b0);
        n_cmp++; if (irr !== 1'b1)      begin n_bad++; $display("FAIL post_glitch_irr: got %b want 1", irr); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL post_glitch_data: got %h want 00", rx_data); end
        ack_pulse();
    endtask

    task automatic test_spike();
        logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
        want = 8'h5A;
`else
        want = 8'hA5;
`endif
        exp_q.push_back(want);
        send_frame(8'h5A, 1'b1, 1'b1);
        n_cmp++; if (irr !== 1'b1)   begin n_bad++; $display("FAIL spike_irr: got %b want 1", irr); end
        n_cmp++; if (rx_data !== want) begin n_bad++; $display("FAIL spike_data: got %h want %h", rx_data, want); end
        ack_pulse();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ack_collision();
        test_frame_err();
        test_glitch();
        test_spike();
        cycles(5);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d bytes never committed, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
